// File: rtl/axi_interconnect_crossbar_wr_sched_pkg.sv
// Shared types and constants for the crossbar slave-port write scheduler.
// State encoding, beat-counter width and the index-width helper.
package axi_interconnect_crossbar_wr_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int BEAT_W = 16;

    // Bits needed to hold the value n, never less than one.
    function automatic int LOG2(input int n);
        int r;
        r = 1;
        while ((1 << r) <= n) r++;
        return r;
    endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_wr_sched_if.sv
// Handshake bundle between NUM masters, the shared slave AW/W pair and the scheduler.
// The slave modport is the scheduler side; the master modport drives stimulus and ready.
interface axi_interconnect_crossbar_wr_sched_if
    import axi_interconnect_crossbar_wr_sched_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int WIDTH = LOG2(NUM - 1)
);
    logic [NUM-1:0]    m_awvalid;
    logic [NUM-1:0]    m_awready;
    logic [NUM-1:0]    m_wvalid;
    logic [NUM-1:0]    m_wlast;
    logic [NUM-1:0]    m_wready;
    logic              s_awvalid;
    logic              s_awready;
    logic              s_wvalid;
    logic              s_wlast;
    logic              s_wready;
    logic              grant_vld;
    logic [WIDTH-1:0]  grant_sel;
    logic [BEAT_W-1:0] wr_beats;

    modport slave (
        input  m_awvalid, m_wvalid, m_wlast, s_awready, s_wready,
        output m_awready, m_wready, s_awvalid, s_wvalid, s_wlast,
        output grant_vld, grant_sel, wr_beats
    );

    modport master (
        output m_awvalid, m_wvalid, m_wlast, s_awready, s_wready,
        input  m_awready, m_wready, s_awvalid, s_wvalid, s_wlast,
        input  grant_vld, grant_sel, wr_beats
    );
endinterface

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
// Round-robin polling arbiter: picks the first requester strictly after last_user.
// Purely combinational; the caller decides when to register the result.
module axi_interconnect_crossbar_arbit_polling #(
    parameter int NUM   = 4,
    parameter int WIDTH = 2
) (
    input  logic [NUM-1:0]   user_req,
    input  logic [WIDTH-1:0] last_user,
    output logic [WIDTH-1:0] current_user
);
    int   idx;
    logic found;

    always_comb begin
        current_user = '0;
        found        = 1'b0;
        idx          = 0;
        for (int i = 1; i <= NUM; i++) begin
            idx = (int'(last_user) + i) % NUM;
            if (!found && user_req[idx]) begin
                current_user = WIDTH'(idx);
                found        = 1'b1;
            end
        end
    end
endmodule

// File: rtl/axi_interconnect_crossbar_wr_sched.sv
// Write-path scheduler sharing one slave AW/W pair among NUM masters, grant held AW issue to wlast.
// One cycle from m_awvalid to s_awvalid; ready/valid pass straight through to the granted master.
module axi_interconnect_crossbar_wr_sched
    import axi_interconnect_crossbar_wr_sched_pkg::*;
#(
    parameter int NUM   = 4,
    parameter int WIDTH = LOG2(NUM - 1)
) (
    input  logic clk,
    input  logic rst,
    axi_interconnect_crossbar_wr_sched_if.slave bus
);
    state_t            state, state_nxt;
    logic [WIDTH-1:0]  last_user, grant_sel, winner;
    logic              aw_done, w_done;
    logic [BEAT_W-1:0] wr_beats;
    logic              aw_hs, w_hs, wlast_hs, done;
    logic              s_awvalid, s_wvalid, s_wlast;
    logic [NUM-1:0]    m_awready, m_wready;

    axi_interconnect_crossbar_arbit_polling #(
        .NUM   (NUM),
        .WIDTH (WIDTH)
    ) u_arb (
        .user_req     (bus.m_awvalid),
        .last_user    (last_user),
        .current_user (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        wlast_hs  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|bus.m_awvalid) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                s_awvalid            = bus.m_awvalid[grant_sel] & ~aw_done;
                m_awready[grant_sel] = bus.s_awready & ~aw_done;
                s_wvalid             = bus.m_wvalid[grant_sel] & ~w_done;
                s_wlast              = bus.m_wlast[grant_sel];
                m_wready[grant_sel]  = bus.s_wready & ~w_done;
                aw_hs    = s_awvalid & bus.s_awready;
                w_hs     = s_wvalid & bus.s_wready;
                wlast_hs = w_hs & s_wlast;
                // AW and the last W may finish in either order or together.
                done     = (aw_done | aw_hs) & (w_done | wlast_hs);
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_user <= WIDTH'(NUM - 1);
            grant_sel <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            wr_beats  <= '0;
        end else if (state == ST_IDLE) begin
            if (|bus.m_awvalid) begin
                grant_sel <= winner;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
                wr_beats  <= '0;
            end
        end else begin
            if (aw_hs)    aw_done <= 1'b1;
            if (wlast_hs) w_done  <= 1'b1;
            if (w_hs && (wr_beats != {BEAT_W{1'b1}})) wr_beats <= wr_beats + BEAT_W'(1);
            // Done flags only matter inside a burst; drop them on the way out.
            if (done) begin
                last_user <= grant_sel;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
            end
        end
    end

    assign bus.s_awvalid = s_awvalid;
    assign bus.s_wvalid  = s_wvalid;
    assign bus.s_wlast   = s_wlast;
    assign bus.m_awready = m_awready;
    assign bus.m_wready  = m_wready;
    assign bus.grant_vld = (state == ST_BUSY);
    assign bus.grant_sel = grant_sel;
    assign bus.wr_beats  = wr_beats;
endmodule

// File: doc/axi_interconnect_crossbar_wr_sched.md
Name: axi_interconnect_crossbar_wr_sched

Overview:
Write-path scheduler for one crossbar slave port. Shares a single slave AW/W channel pair between NUM masters, using round-robin (polling) arbitration. A grant is locked from AW issue until the final W beat (wlast) has been accepted. Handles only valid/ready/last handshakes and the select index; the AW/W payload muxes sit outside and are steered by grant_sel.

Parameters:
NUM, 4, number of requesting masters (>=2)
WIDTH, LOG2(NUM-1) (min 1), width of master index / grant_sel

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
m_awvalid  in  NUM  per-master AW valid
m_awready  out  NUM  per-master AW ready (only the granted bit can be 1)
m_wvalid  in  NUM  per-master W valid
m_wlast  in  NUM  per-master W last
m_wready  out  NUM  per-master W ready (only the granted bit can be 1)
s_awvalid  out  1  slave-side AW valid
s_awready  in  1  slave-side AW ready
s_wvalid  out  1  slave-side W valid
s_wlast  out  1  slave-side W last
s_wready  in  1  slave-side W ready
grant_vld  out  1  grant active (state BUSY)
grant_sel  out  WIDTH  granted master index, payload mux select
wr_beats  out  16  W beats accepted in current burst, saturating

Behaviour:
- Registered state: state{IDLE,BUSY}, last_user[WIDTH], grant_sel, aw_done, w_done, wr_beats.
- Reset values: state=IDLE, last_user=NUM-1 (master 0 has top priority after reset), grant_sel=0, grant_vld=0, aw_done=0, w_done=0, wr_beats=0. All combinational outputs are 0 while rst=1.
- IDLE:
  - Arbitration request vector = m_awvalid.
  - If any bit is set, the polling arbiter picks the first requester strictly after last_user, wrapping modulo NUM.
  - On the next edge: grant_sel<=winner, state<=BUSY, aw_done/w_done/wr_beats cleared.
  - If no bit is set, stay in IDLE.
  - In IDLE, all m_*ready and s_*valid outputs are 0. Latency from m_awvalid to s_awvalid is 1 cycle.
- BUSY, g=grant_sel:
  - s_awvalid = m_awvalid[g] & ~aw_done.
  - m_awready[g] = s_awready & ~aw_done.
  - s_wvalid = m_wvalid[g] & ~w_done.
  - s_wlast = m_wlast[g].
  - m_wready[g] = s_wready & ~w_done.
  - All other m_*ready bits are 0.
- AW handshake (s_awvalid & s_awready): aw_done<=1.
- W beat accepted (s_wvalid & s_wready): wr_beats<=wr_beats+1, saturating at 16'hFFFF.
- W beat accepted with s_wlast=1: w_done<=1.
- AW and W completion may occur in either order or in the same cycle. W data preceding AW is legal and is forwarded.
- Exit condition: (aw_done|aw_hs) & (w_done|wlast_hs).
  - On exit: state<=IDLE, last_user<=grant_sel, grant_vld<=0.
  - Earliest re-arbitration is the cycle after exit. Minimum cycle per transaction is 2 clocks (one IDLE, one BUSY).
- A granted master that drops m_awvalid or m_wvalid mid-transaction (protocol violation) does not release the grant. The scheduler waits.
- Requests from non-granted masters during BUSY are ignored and are not queued. They are re-evaluated in IDLE.
- Reset asserted mid-burst forces IDLE immediately and asynchronously. An in-flight burst is abandoned with no cleanup beat.
- grant_sel holds its last value in IDLE and is not cleared. Consumers qualify it with grant_vld.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=1'b0, ST_BUSY=1'b1), the LOG2 function, and the beat-counter width constant (16).
- Sub-module: instantiate the existing axi_interconnect_crossbar_arbit_polling (NUM, WIDTH) with user_req=m_awvalid and last_user=last_user.
  - Its current_user output is registered into grant_sel only in IDLE when |m_awvalid.
  - It is not a copy of that arbiter; no other sub-modules.

Test Plan:
1. After reset, m_awvalid=4'b1111 held, each burst 1 beat with wlast=1 and slaves always ready -> grants cycle 0,1,2,3,0. One grant per 2 clocks.
2. m_awvalid=4'b0101, last_user=0 -> grant 2. After that completes, grant 0. Master 1 and master 3 never see ready.
3. Granted master 1 sends 4 W beats with wlast on beat 4 before s_awready rises on cycle 6 -> wr_beats=4, w_done=1. BUSY holds until the AW handshake, then IDLE the next cycle with last_user=1.
4. AW and last W handshake in the same cycle -> exit that edge. aw_done and w_done never both register. Next IDLE arbitrates normally.
5. s_wready toggling 1,0,1,0 over an 8-beat burst -> wr_beats increments only on accepted beats, reaching 8. Non-granted m_wready stays 0 throughout.
6. rst asserted while BUSY with wr_beats=3 -> all outputs 0 within the same cycle. After release, the first grant goes to the lowest-index requester (last_user=3).
